// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, opcodes, field positions, decoded controls.
// Build option: DECODE_R0_ZERO_EN hard-wires r0 to zero in decode.
package cpu_pkg;

  localparam int CPU_DATA_W  = 8;
  localparam int CPU_ADDR_W  = 3;
  localparam int CPU_INSTR_W = 16;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_LD   = 4'd6;
  localparam logic [3:0] OP_ST   = 4'd7;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS1_HI = 8;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 3;
  localparam int IMM_HI = 5;
  localparam int IMM_LO = 0;

  typedef struct packed {
    logic we;
    logic is_load;
    logic is_store;
    logic uses_rs1;
    logic uses_rs2;
    logic use_imm;
  } ctrl_t;

  function automatic ctrl_t decode_op(input logic [3:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        c.we       = 1'b1;
        c.uses_rs1 = 1'b1;
        c.uses_rs2 = 1'b1;
      end
      OP_ADDI: begin
        c.we       = 1'b1;
        c.uses_rs1 = 1'b1;
        c.use_imm  = 1'b1;
      end
      OP_LD: begin
        c.we       = 1'b1;
        c.is_load  = 1'b1;
        c.uses_rs1 = 1'b1;
        c.use_imm  = 1'b1;
      end
      OP_ST: begin
        c.is_store = 1'b1;
        c.uses_rs1 = 1'b1;
        c.uses_rs2 = 1'b1;
        c.use_imm  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_bypass.sv
// Operand bypass mux: EX/MEM result, then writeback, then register file.
// Build option: DECODE_R0_ZERO_EN forces index 0 to read zero.
module operand_bypass #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic [ADDR_W-1:0] i_rs,
  input  logic              i_mem_we,
  input  logic [ADDR_W-1:0] i_mem_rd,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_wb_we,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic [DATA_W-1:0] i_rf_data,
  output logic [DATA_W-1:0] o_data
);

  logic w_nz;

`ifdef DECODE_R0_ZERO_EN
  assign w_nz = |i_rs;
`else
  assign w_nz = 1'b1;
`endif

  always_comb begin
    o_data = i_rf_data;
    if (!w_nz)
      o_data = '0;
    else if (i_mem_we && (i_mem_rd == i_rs))
      o_data = i_mem_data;
    else if (i_wb_we && (i_wb_addr == i_rs))
      o_data = i_wb_data;
  end

endmodule

// File: rtl/decode_stage.sv
// ID stage: decode, operand bypass, load-use stall, ID/EX register.
// Build option: DECODE_R0_ZERO_EN makes r0 read as zero and never written.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W  = CPU_DATA_W,
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int INSTR_W = CPU_INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_valid,
  input  logic [INSTR_W-1:0] if_instr,
  output logic               if_ready,
  output logic [ADDR_W-1:0]  read_addr1,
  output logic [ADDR_W-1:0]  read_addr2,
  input  logic [DATA_W-1:0]  read_data1,
  input  logic [DATA_W-1:0]  read_data2,
  input  logic               mem_fwd_we,
  input  logic [ADDR_W-1:0]  mem_fwd_rd,
  input  logic [DATA_W-1:0]  mem_fwd_data,
  input  logic               wb_we,
  input  logic [ADDR_W-1:0]  wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               flush,
  input  logic               ex_ready,
  output logic               ex_valid,
  output logic [3:0]         ex_op,
  output logic [ADDR_W-1:0]  ex_rd,
  output logic [DATA_W-1:0]  ex_a,
  output logic [DATA_W-1:0]  ex_b,
  output logic [DATA_W-1:0]  ex_st_data,
  output logic               ex_we,
  output logic               ex_is_load,
  output logic               ex_is_store
);

  logic [3:0]        w_op;
  logic [ADDR_W-1:0] w_rd;
  logic [ADDR_W-1:0] w_rs1;
  logic [ADDR_W-1:0] w_rs2;
  logic [5:0]        w_imm6;
  logic [DATA_W-1:0] w_imm;
  ctrl_t             w_ctrl;
  logic [DATA_W-1:0] w_opa;
  logic [DATA_W-1:0] w_opb;
  logic [DATA_W-1:0] w_b;
  logic              w_we;
  logic              w_rs1_hit;
  logic              w_rs2_hit;
  logic              w_hazard;
  logic              w_adv;

  logic              r_valid;
  logic [3:0]        r_op;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_sd;
  logic              r_we;
  logic              r_ld;
  logic              r_st;

  assign w_op   = if_instr[OP_HI:OP_LO];
  assign w_rd   = if_instr[RD_HI:RD_LO];
  assign w_rs1  = if_instr[RS1_HI:RS1_LO];
  assign w_rs2  = if_instr[RS2_HI:RS2_LO];
  assign w_imm6 = if_instr[IMM_HI:IMM_LO];
  assign w_imm  = {{(DATA_W-6){w_imm6[5]}}, w_imm6};
  assign w_ctrl = decode_op(w_op);

  assign read_addr1 = w_rs1;
  assign read_addr2 = w_rs2;

  operand_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp1 (
    .i_rs       (w_rs1),
    .i_mem_we   (mem_fwd_we),
    .i_mem_rd   (mem_fwd_rd),
    .i_mem_data (mem_fwd_data),
    .i_wb_we    (wb_we),
    .i_wb_addr  (wb_addr),
    .i_wb_data  (wb_data),
    .i_rf_data  (read_data1),
    .o_data     (w_opa)
  );

  operand_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp2 (
    .i_rs       (w_rs2),
    .i_mem_we   (mem_fwd_we),
    .i_mem_rd   (mem_fwd_rd),
    .i_mem_data (mem_fwd_data),
    .i_wb_we    (wb_we),
    .i_wb_addr  (wb_addr),
    .i_wb_data  (wb_data),
    .i_rf_data  (read_data2),
    .o_data     (w_opb)
  );

  assign w_b = w_ctrl.use_imm ? w_imm : w_opb;

`ifdef DECODE_R0_ZERO_EN
  assign w_we      = w_ctrl.we & (|w_rd);
  assign w_rs1_hit = (r_rd == w_rs1) & (|w_rs1);
  assign w_rs2_hit = (r_rd == w_rs2) & (|w_rs2);
`else
  assign w_we      = w_ctrl.we;
  assign w_rs1_hit = (r_rd == w_rs1);
  assign w_rs2_hit = (r_rd == w_rs2);
`endif

  assign w_hazard = r_valid & r_ld & r_we &
                    ((w_ctrl.uses_rs1 & w_rs1_hit) |
                     (w_ctrl.uses_rs2 & w_rs2_hit));
  assign w_adv    = ex_ready | ~r_valid;
  assign if_ready = w_adv & ~w_hazard & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_op    <= '0;
      r_rd    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sd    <= '0;
      r_we    <= 1'b0;
      r_ld    <= 1'b0;
      r_st    <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (!w_adv) begin
      r_valid <= r_valid;
    end else if (w_hazard && if_valid) begin
      // bubble: payload is stale, only control is cleared
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_ld    <= 1'b0;
      r_st    <= 1'b0;
    end else if (if_valid) begin
      r_valid <= 1'b1;
      r_op    <= w_op[3] ? OP_NOP : w_op;
      r_rd    <= w_rd;
      r_a     <= w_opa;
      r_b     <= w_b;
      r_sd    <= w_opb;
      r_we    <= w_we;
      r_ld    <= w_ctrl.is_load;
      r_st    <= w_ctrl.is_store;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign ex_valid    = r_valid;
  assign ex_op       = r_op;
  assign ex_rd       = r_rd;
  assign ex_a        = r_a;
  assign ex_b        = r_b;
  assign ex_st_data  = r_sd;
  assign ex_we       = r_we;
  assign ex_is_load  = r_ld;
  assign ex_is_store = r_st;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed vectors, queued expectations.
// Expectations for r0 follow DECODE_R0_ZERO_EN when it is defined.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [15:0] if_instr;
  logic        if_ready;
  logic [2:0]  read_addr1;
  logic [2:0]  read_addr2;
  logic [7:0]  read_data1;
  logic [7:0]  read_data2;
  logic        mem_fwd_we;
  logic [2:0]  mem_fwd_rd;
  logic [7:0]  mem_fwd_data;
  logic        wb_we;
  logic [2:0]  wb_addr;
  logic [7:0]  wb_data;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [2:0]  ex_rd;
  logic [7:0]  ex_a;
  logic [7:0]  ex_b;
  logic [7:0]  ex_st_data;
  logic        ex_we;
  logic        ex_is_load;
  logic        ex_is_store;

`ifdef DECODE_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [2:0] rd;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sd;
    logic       we;
    logic       ld;
    logic       st;
    bit         chk_data;
    bit         chk_sd;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   errors = 0;
  int   checks = 0;

  decode_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_ready     (if_ready),
    .read_addr1   (read_addr1),
    .read_addr2   (read_addr2),
    .read_data1   (read_data1),
    .read_data2   (read_data2),
    .mem_fwd_we   (mem_fwd_we),
    .mem_fwd_rd   (mem_fwd_rd),
    .mem_fwd_data (mem_fwd_data),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .flush        (flush),
    .ex_ready     (ex_ready),
    .ex_valid     (ex_valid),
    .ex_op        (ex_op),
    .ex_rd        (ex_rd),
    .ex_a         (ex_a),
    .ex_b         (ex_b),
    .ex_st_data   (ex_st_data),
    .ex_we        (ex_we),
    .ex_is_load   (ex_is_load),
    .ex_is_store  (ex_is_store)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input string nm, input logic [3:0] op,
                      input logic [2:0] rd, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] sd,
                      input logic we, input logic ld, input logic st,
                      input bit cd, input bit cs);
    exp_t e;
    e.name = nm; e.op = op; e.rd = rd; e.a = a; e.b = b; e.sd = sd;
    e.we = we; e.ld = ld; e.st = st; e.chk_data = cd; e.chk_sd = cs;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expectation consumed per accepted ID/EX transfer
  always @(negedge clk) begin
    if (rst_n && ex_valid && ex_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got op %0h expected none", ex_op);
      end else begin
        m_e = q.pop_front();
        chk({m_e.name, ".we"}, 32'(ex_we), 32'(m_e.we));
        chk({m_e.name, ".ld"}, 32'(ex_is_load), 32'(m_e.ld));
        chk({m_e.name, ".st"}, 32'(ex_is_store), 32'(m_e.st));
        if (m_e.chk_data) begin
          chk({m_e.name, ".op"}, 32'(ex_op), 32'(m_e.op));
          chk({m_e.name, ".rd"}, 32'(ex_rd), 32'(m_e.rd));
          chk({m_e.name, ".a"}, 32'(ex_a), 32'(m_e.a));
          chk({m_e.name, ".b"}, 32'(ex_b), 32'(m_e.b));
        end
        if (m_e.chk_sd)
          chk({m_e.name, ".sd"}, 32'(ex_st_data), 32'(m_e.sd));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_instr = '0;
    read_data1 = '0; read_data2 = '0;
    mem_fwd_we = 1'b0; mem_fwd_rd = '0; mem_fwd_data = '0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    flush = 1'b0; ex_ready = 1'b1;
    #12;
    chk("rst_valid", 32'(ex_valid), 0);
    chk("rst_a", 32'(ex_a), 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", 32'(ex_valid), 0);
    chk("post_rst_ready", 32'(if_ready), 1);

    // ADD r3,r1,r2
    if_valid = 1'b1; if_instr = 16'h1650;
    read_data1 = 8'h05; read_data2 = 8'h0A;
    #1 chk("raddr1", 32'(read_addr1), 1);
    chk("raddr2", 32'(read_addr2), 2);
    push("add", 4'd1, 3'd3, 8'h05, 8'h0A, 8'h0A, 1, 0, 0, 1, 0);
    step();

    // SUB r4,r1,r1 with wb bypass, then with mem overriding wb
    if_instr = 16'h2848; read_data1 = 8'h00; read_data2 = 8'h00;
    wb_we = 1'b1; wb_addr = 3'd1; wb_data = 8'h33;
    push("sub_wb", 4'd2, 3'd4, 8'h33, 8'h33, 8'h33, 1, 0, 0, 1, 0);
    step();
    mem_fwd_we = 1'b1; mem_fwd_rd = 3'd1; mem_fwd_data = 8'h44;
    push("sub_mem", 4'd2, 3'd4, 8'h44, 8'h44, 8'h44, 1, 0, 0, 1, 0);
    step();
    mem_fwd_we = 1'b0; wb_we = 1'b0;

    // ST rs1=r3, rs2=r4, imm6=0x22
    if_instr = 16'h70E2; read_data1 = 8'h40; read_data2 = 8'h55;
    push("st", 4'd7, 3'd0, 8'h40, 8'hE2, 8'h55, 0, 0, 1, 1, 1);
    step();

    // illegal opcode behaves as a valid NOP
    if_instr = 16'h9FFF;
    push("illegal", 4'd0, 3'd0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    step();

    // LD r2,1(r0) then dependent ADD r5,r2,r2
    if_instr = 16'h6401; read_data1 = 8'h10; read_data2 = 8'h00;
    push("ld", 4'd6, 3'd2, R0Z ? 8'h00 : 8'h10, 8'h01, 8'h00,
         1, 1, 0, 1, 0);
    step();
    if_instr = 16'h1A90; read_data1 = 8'h00;
    #1 chk("lu_stall_ready", 32'(if_ready), 0);
    step();
    chk("lu_bubble_valid", 32'(ex_valid), 0);
    chk("lu_bubble_load", 32'(ex_is_load), 0);
    mem_fwd_we = 1'b1; mem_fwd_rd = 3'd2; mem_fwd_data = 8'h7E;
    #1 chk("lu_resume_ready", 32'(if_ready), 1);
    push("lu_add", 4'd1, 3'd5, 8'h7E, 8'h7E, 8'h7E, 1, 0, 0, 1, 0);
    step();
    mem_fwd_we = 1'b0;

    // ADDI r1,r0,-1 and ADD r0,r1,r1
    if_instr = 16'h523F; read_data1 = 8'h99; read_data2 = 8'h22;
    push("addi", 4'd5, 3'd1, R0Z ? 8'h00 : 8'h99, 8'hFF, 8'h22,
         1, 0, 0, 1, 0);
    step();
    if_instr = 16'h1048; read_data1 = 8'h03; read_data2 = 8'h03;
    push("add_r0", 4'd1, 3'd0, 8'h03, 8'h03, 8'h03, !R0Z, 0, 0, 1, 0);
    step();

    // backpressure: OR held while EX stalls, AND waits in IF
    if_instr = 16'h4CE0; read_data1 = 8'h0F; read_data2 = 8'hF0;
    push("or", 4'd4, 3'd6, 8'h0F, 8'hF0, 8'hF0, 1, 0, 0, 1, 0);
    step();
    ex_ready = 1'b0;
    if_instr = 16'h3EE0; read_data1 = 8'h3C; read_data2 = 8'h0F;
    push("and", 4'd3, 3'd7, 8'h3C, 8'h0F, 8'h0F, 1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 32'(if_ready), 0);
      chk("bp_hold_a", 32'(ex_a), 32'h0F);
      chk("bp_hold_valid", 32'(ex_valid), 1);
      step();
    end
    ex_ready = 1'b1;
    step();

    // flush drops the incoming instruction
    if_instr = 16'h1650; read_data1 = 8'h05; read_data2 = 8'h0A;
    flush = 1'b1;
    #1 chk("flush_ready", 32'(if_ready), 0);
    step();
    chk("flush_valid", 32'(ex_valid), 0);
    flush = 1'b0; if_valid = 1'b0;
    step();

    // asynchronous reset mid-stream
    if_valid = 1'b1; if_instr = 16'h1650;
    step();
    if_valid = 1'b0;
    chk("mid_valid_pre", 32'(ex_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ex_valid), 0);
    chk("arst_op", 32'(ex_op), 0);
    chk("arst_rd", 32'(ex_rd), 0);
    chk("arst_a", 32'(ex_a), 0);
    chk("arst_b", 32'(ex_b), 0);
    chk("arst_we", 32'(ex_we), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("rel_valid", 32'(ex_valid), 0);
    chk("rel_ready", 32'(if_ready), 1);

    repeat (3) step();
    chk("queue_empty", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the 8-bit pipelined CPU; sits directly upstream of register_file and the EX stage.
- Accepts 16-bit instructions from IF over a valid/ready handshake and drives the register_file read addresses.
- Resolves operands with MEM/WB bypassing, inserts a bubble on load-use hazards, and registers the decoded result into the ID/EX pipeline register.

Parameters:
- DATA_W, 8, register/operand width
- ADDR_W, 3, register index width (8 registers)
- INSTR_W, 16, instruction width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  IF holds an instruction
- if_instr  in  INSTR_W  instruction word
- if_ready  out  1  decode accepts if_instr this cycle
- read_addr1  out  ADDR_W  to register_file, rs1 field
- read_addr2  out  ADDR_W  to register_file, rs2 field
- read_data1  in  DATA_W  from register_file
- read_data2  in  DATA_W  from register_file
- mem_fwd_we  in  1  EX/MEM instruction writes a register
- mem_fwd_rd  in  ADDR_W  its destination
- mem_fwd_data  in  DATA_W  its result, valid for loads too
- wb_we  in  1  writeback enable, same signal as register_file we
- wb_addr  in  ADDR_W  writeback address
- wb_data  in  DATA_W  writeback data
- flush  in  1  synchronous pipeline flush
- ex_ready  in  1  EX accepts ID/EX contents
- ex_valid  out  1  ID/EX holds a valid instruction
- ex_op  out  4  opcode
- ex_rd  out  ADDR_W  destination
- ex_a  out  DATA_W  operand A (rs1)
- ex_b  out  DATA_W  operand B (rs2 or sign-extended imm)
- ex_st_data  out  DATA_W  store data (rs2)
- ex_we  out  1  instruction writes rd
- ex_is_load  out  1  LD
- ex_is_store  out  1  ST

Behaviour:
- Reset is asynchronous and active-low.
- Reset values: all ex_* outputs are 0.
- Instruction format:
  - op = [15:12]
  - rd = [11:9]
  - rs1 = [8:6]
  - rs2 = [5:3]
  - imm6 = [5:0], sign-extended to DATA_W
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR: we, uses rs1 and rs2, b = rs2
  - 5 ADDI: we, rs1, b = imm
  - 6 LD: we, is_load, rs1, b = imm
  - 7 ST: rs1 and rs2, b = imm, st_data = rs2
  - 8–15: illegal, decoded as NOP (we = 0, valid preserved)
- read_addr1/2 are driven combinationally from if_instr rs1/rs2 every cycle.
- Operand select, per operand, in priority order:
  - mem_fwd_we && mem_fwd_rd == rs → mem_fwd_data
  - otherwise wb_we && wb_addr == rs → wb_data; this covers the same-cycle write that register_file has not yet committed
  - otherwise read_data
- Advance condition: adv = ex_ready | ~ex_valid.
- Load-use hazard: ex_valid & ex_is_load & ex_we & ((uses_rs1 & ex_rd == rs1) | (uses_rs2 & ex_rd == rs2)), with the operands taken from if_instr.
- if_ready = adv & ~hazard & ~flush.
- Each posedge, in priority order:
  - flush → ex_valid <= 0; the incoming instruction is dropped.
  - else !adv → ID/EX holds all fields unchanged.
  - else hazard & if_valid → bubble: ex_valid <= 0, ex_we <= 0, ex_is_load <= 0, ex_is_store <= 0. The stall lasts exactly 1 cycle, after which the load value arrives via mem_fwd.
  - else if_valid → capture the decoded instruction, ex_valid <= 1.
  - else → ex_valid <= 0.
- Data fields of a bubble are don't-care; control fields are forced to 0.
- Latency: 1 cycle, IF acceptance to ex_valid.
- Throughput: 1 instruction/cycle with no hazard or backpressure.

Optional Feature:
- Macro: DECODE_R0_ZERO_EN.
- Defined: register 0 reads as 0 regardless of register_file or bypass contents. rd = 0 produces ex_we = 0. No forwarding or hazard match occurs on index 0.
- Undefined: r0 is an ordinary register.

Decomposition:
- Package cpu_pkg holds:
  - opcode localparams (OP_NOP … OP_ST)
  - field bit-position constants
  - DATA_W/ADDR_W defaults
  - a decoded-control struct (we, is_load, is_store, uses_rs1, uses_rs2, use_imm)
- One natural sub-module, operand_bypass: a purely combinational 3-way mux with the priority above, instantiated once per operand.

Test Plan:
- Reset: assert rst_n = 0 mid-stream → all ex_* = 0 immediately (asynchronous). After release with if_valid = 0: ex_valid stays 0 and if_ready = 1.
- ADD r3, r1, r2, with read_data1 = 0x05, read_data2 = 0x0A and no forwarding → next cycle: ex_valid = 1, ex_op = 1, ex_rd = 3, ex_a = 0x05, ex_b = 0x0A, ex_we = 1.
- Bypass priority, for SUB r4, r1, r1:
  - wb_we = 1, wb_addr = 1, wb_data = 0x33, read_data1 = 0x00 → ex_a = ex_b = 0x33.
  - Additionally mem_fwd_we = 1, mem_fwd_rd = 1, mem_fwd_data = 0x44 → ex_a = 0x44.
- Load-use: LD r2, 1(r0) followed by ADD r5, r2, r2 → if_ready = 0 for one cycle and a bubble (ex_valid = 0). Next cycle mem_fwd_rd = 2, mem_fwd_data = 0x7E → ADD captured with ex_a = ex_b = 0x7E.
- Backpressure/flush:
  - ex_ready = 0 for 3 cycles → ID/EX stable and if_ready = 0.
  - flush = 1 with if_valid = 1 → next cycle ex_valid = 0 and the instruction is not accepted.
- ADDI r1, r0, -1 (imm6 = 0x3F):
  - Macro on: ex_b = 0xFF, ex_a = 0 even when read_data1 = 0x99.
  - ADD r0, r1, r1 with macro on → ex_we = 0.
